fork_n_avlstrm: RTL and testbench

//  Parametrised N-way packet fork for Avalon-ST. Routes each whole packet from one input

---
 rtl/fork_n_avlstrm.sv | 128 ++++++++++++
 tb/tb_fork_n_avlstrm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fork_n_avlstrm.sv
// fork_n_avlstrm: N-way Avalon-ST packet fork routed by in_channel on SOP, with a drop path and per-route stats.
// Optional broadcast on all-ones channel enabled by defining FORK_BROADCAST_EN.
module fork_n_avlstrm #(
  parameter int WIDTH   = 512,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 4,
  parameter int EMPTY_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [EMPTY_W-1:0]         in_empty,
  input  logic [SEL_W-1:0]           in_channel,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT-1:0]         out_sop,
  output logic [NUM_OUT-1:0]         out_eop,
  output logic [NUM_OUT*EMPTY_W-1:0] out_empty,
  output logic [NUM_OUT*32-1:0]      stats_out_pkt,
  output logic [31:0]                stats_drop_pkt,
  output logic [31:0]                stats_err
);
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
  state_t                     state_q, state_d;
  logic [SEL_W-1:0]           dest_q, dest_d;
  logic                       bcast_q, bcast_d;
  logic [NUM_OUT*WIDTH-1:0]   out_data_q, out_data_d;
  logic [NUM_OUT-1:0]         out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0]         out_sop_q, out_sop_d;
  logic [NUM_OUT-1:0]         out_eop_q, out_eop_d;
  logic [NUM_OUT*EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic [NUM_OUT*32-1:0]      stats_out_q, stats_out_d;
  logic [31:0]                stats_drop_q, stats_drop_d;
  logic [31:0]                stats_err_q, stats_err_d;
  logic [NUM_OUT-1:0]         free, wr;
  logic [2**SEL_W-1:0]        free_x;
  logic                       sop_bcast, in_range, cur_bcast, cur_fwd, acc, err_ev, drop_ev;
  logic [SEL_W-1:0]           cur_dest;
`ifdef FORK_BROADCAST_EN
  assign sop_bcast = &in_channel;
`else
  assign sop_bcast = 1'b0;
`endif
  // An SOP beat re-routes from any state; otherwise the held route applies.
  always_comb begin
    free      = ~out_valid_q | out_ready;
    free_x    = '0;
    free_x[NUM_OUT-1:0] = free;
    in_range  = {1'b0, in_channel} < (SEL_W+1)'(NUM_OUT);
    cur_bcast = in_sop ? sop_bcast : bcast_q;
    cur_dest  = in_sop ? in_channel : dest_q;
    cur_fwd   = in_sop ? (sop_bcast | in_range) : (state_q == FWD);
    in_ready  = rst_n & (!cur_fwd | (cur_bcast ? &free : free_x[cur_dest]));
    acc       = in_valid & in_ready;
    err_ev    = acc & ((state_q == IDLE) ^ in_sop);
    drop_ev   = acc & in_sop & !cur_fwd;
    state_d   = state_q;
    dest_d    = dest_q;
    bcast_d   = bcast_q;
    if (acc & in_sop) begin
      dest_d  = in_channel;
      bcast_d = sop_bcast;
      state_d = in_eop ? IDLE : (cur_fwd ? FWD : DROP);
    end else if (acc & in_eop) begin
      state_d = IDLE;
    end
    stats_drop_d = stats_drop_q + 32'(drop_ev);
    stats_err_d  = stats_err_q + 32'(err_ev);
  end
  always_comb begin
    wr          = '0;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_empty_d = out_empty_q;
    stats_out_d = stats_out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      wr[k]          = acc & cur_fwd & (cur_bcast | (cur_dest == SEL_W'(k)));
      out_valid_d[k] = wr[k] | (out_valid_q[k] & !out_ready[k]);
      out_sop_d[k]   = wr[k] ? in_sop : out_sop_q[k];
      out_eop_d[k]   = wr[k] ? in_eop : out_eop_q[k];
      out_data_d[k*WIDTH +: WIDTH]     = wr[k] ? in_data : out_data_q[k*WIDTH +: WIDTH];
      out_empty_d[k*EMPTY_W +: EMPTY_W] = wr[k] ? in_empty : out_empty_q[k*EMPTY_W +: EMPTY_W];
      stats_out_d[k*32 +: 32] = stats_out_q[k*32 +: 32] + 32'(out_valid_q[k] & out_ready[k] & out_eop_q[k]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      bcast_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      out_sop_q    <= '0;
      out_eop_q    <= '0;
      out_empty_q  <= '0;
      stats_out_q  <= '0;
      stats_drop_q <= '0;
      stats_err_q  <= '0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      bcast_q      <= bcast_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      stats_out_q  <= stats_out_d;
      stats_drop_q <= stats_drop_d;
      stats_err_q  <= stats_err_d;
    end
  end
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_sop        = out_sop_q;
  assign out_eop        = out_eop_q;
  assign out_empty      = out_empty_q;
  assign stats_out_pkt  = stats_out_q;
  assign stats_drop_pkt = stats_drop_q;
  assign stats_err      = stats_err_q;
endmodule

// File: tb/tb_fork_n_avlstrm.sv
// tb_fork_n_avlstrm: table-driven check of fork_n_avlstrm with NUM_OUT=4, plus hand-written stall, reset and broadcast sequences.
module tb_fork_n_avlstrm;
  localparam int W = 32, N = 4, S = 4, E = 2;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
  logic [E-1:0]   in_empty = '0;
  logic [S-1:0]   in_channel = '0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid, out_ready = '1, out_sop, out_eop;
  logic [N*E-1:0] out_empty;
  logic [N*32-1:0] stats_out_pkt;
  logic [31:0]    stats_drop_pkt, stats_err;
  int n_chk = 0, n_fail = 0;

  fork_n_avlstrm #(.WIDTH(W), .NUM_OUT(N), .SEL_W(S), .EMPTY_W(E)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .stats_out_pkt(stats_out_pkt),
    .stats_drop_pkt(stats_drop_pkt), .stats_err(stats_err));

  always #5 clk = ~clk;

  typedef struct {
    logic v, s, e;
    logic [3:0] ch;
    logic [31:0] d;
    logic [3:0] ordy;
    logic rdy;
    logic [3:0] ov;
    int p;
    logic [31:0] xd;
    logic xs, xe;
  } vec_t;

  function automatic vec_t mk(logic v, logic s, logic e, logic [3:0] ch, logic [31:0] d,
                              logic [3:0] ordy, logic rdy, logic [3:0] ov, int p,
                              logic [31:0] xd, logic xs, logic xe);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.ch = ch; t.d = d; t.ordy = ordy; t.rdy = rdy;
    t.ov = ov; t.p = p; t.xd = xd; t.xs = xs; t.xe = xe;
    return t;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    in_valid = t.v; in_sop = t.s; in_eop = t.e; in_channel = t.ch;
    in_data = t.d; in_empty = t.d[1:0]; out_ready = t.ordy;
    #1 chk($sformatf("row%0d in_ready", idx), 64'(in_ready), 64'(t.rdy));
    @(posedge clk);
    #1 chk($sformatf("row%0d out_valid", idx), 64'(out_valid), 64'(t.ov));
    if (t.ov != 4'h0) begin
      chk($sformatf("row%0d out_data", idx), 64'(out_data[t.p*W +: W]), 64'(t.xd));
      chk($sformatf("row%0d out_sop", idx), 64'(out_sop[t.p]), 64'(t.xs));
      chk($sformatf("row%0d out_eop", idx), 64'(out_eop[t.p]), 64'(t.xe));
      chk($sformatf("row%0d out_empty", idx), 64'(out_empty[t.p*E +: E]), 64'(t.xd[1:0]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = '1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[$];
    int sent, recv, cyc;
    logic held_f, acc;
    logic [31:0] held;
    // test 1: 3-beat pkt ch2 then single-beat pkt ch0
    tv.push_back(mk(1,1,0,4'd2,32'hA1,4'hF,1,4'h4,2,32'hA1,1,0));
    tv.push_back(mk(1,0,0,4'd0,32'hA2,4'hF,1,4'h4,2,32'hA2,0,0));
    tv.push_back(mk(1,0,1,4'd0,32'hA3,4'hF,1,4'h4,2,32'hA3,0,1));
    tv.push_back(mk(1,1,1,4'd0,32'hB1,4'hF,1,4'h1,0,32'hB1,1,1));
    tv.push_back(mk(0,0,0,4'd0,32'h0,4'hF,1,4'h0,0,32'h0,0,0));
    // test 2: out-of-range channel drops a 5-beat packet
    tv.push_back(mk(1,1,0,4'd9,32'hD1,4'hF,1,4'h0,0,32'h0,0,0));
    tv.push_back(mk(1,0,0,4'd0,32'hD2,4'hF,1,4'h0,0,32'h0,0,0));
    tv.push_back(mk(1,0,0,4'd1,32'hD3,4'hF,1,4'h0,0,32'h0,0,0));
    tv.push_back(mk(1,0,0,4'd2,32'hD4,4'hF,1,4'h0,0,32'h0,0,0));
    tv.push_back(mk(1,0,1,4'd3,32'hD5,4'hF,1,4'h0,0,32'h0,0,0));
    // test 4: stray non-SOP beat in IDLE, then SOP in the middle of a forwarded packet
    tv.push_back(mk(1,0,0,4'd2,32'hE1,4'hF,1,4'h0,0,32'h0,0,0));
    tv.push_back(mk(1,1,0,4'd3,32'hC1,4'hF,1,4'h8,3,32'hC1,1,0));
    tv.push_back(mk(1,0,0,4'd0,32'hC2,4'hF,1,4'h8,3,32'hC2,0,0));
    tv.push_back(mk(1,1,1,4'd1,32'hF1,4'hF,1,4'h2,1,32'hF1,1,1));
    tv.push_back(mk(0,0,0,4'd0,32'h0,4'hF,1,4'h0,0,32'h0,0,0));
    // backpressure on a held slot
    tv.push_back(mk(1,1,0,4'd0,32'h51,4'h0,1,4'h1,0,32'h51,1,0));
    tv.push_back(mk(1,0,1,4'd0,32'h52,4'h0,0,4'h1,0,32'h51,1,0));
    tv.push_back(mk(1,0,1,4'd0,32'h52,4'hF,1,4'h1,0,32'h52,0,1));
    tv.push_back(mk(0,0,0,4'd0,32'h0,4'hF,1,4'h0,0,32'h0,0,0));

    #1 chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset stats_drop", 64'(stats_drop_pkt), 64'd0);
    do_reset();
    foreach (tv[i]) apply(tv[i], i);
    chk("pkt0", 64'(stats_out_pkt[0 +: 32]), 64'd2);
    chk("pkt1", 64'(stats_out_pkt[32 +: 32]), 64'd1);
    chk("pkt2", 64'(stats_out_pkt[64 +: 32]), 64'd1);
    chk("pkt3", 64'(stats_out_pkt[96 +: 32]), 64'd0);
    chk("drop", 64'(stats_drop_pkt), 64'd1);
    chk("err", 64'(stats_err), 64'd2);

    // test 3: 8-beat packet to out1 with out_ready[1] toggling, out_ready[0] low
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = {1'b1, 1'b1, ~cyc[0], 1'b0};
      in_valid = (sent < 8); in_sop = (sent == 0); in_eop = (sent == 7);
      in_channel = 4'd1; in_data = 32'hC000 + 32'(sent); in_empty = '0;
      #1 acc = in_valid & in_ready;
      held_f = 1'b0;
      if (out_valid[1] & out_ready[1]) begin
        chk($sformatf("t3 beat%0d data", recv), 64'(out_data[W +: W]), 64'(32'hC000 + 32'(recv)));
        chk($sformatf("t3 beat%0d sop", recv), 64'(out_sop[1]), 64'(recv == 0));
        chk($sformatf("t3 beat%0d eop", recv), 64'(out_eop[1]), 64'(recv == 7));
        recv++;
      end else if (out_valid[1]) begin
        held_f = 1'b1;
        held = out_data[W +: W];
      end
      @(posedge clk);
      #1;
      if (held_f) begin
        chk("t3 stall valid", 64'(out_valid[1]), 64'd1);
        chk("t3 stall data", 64'(out_data[W +: W]), 64'(held));
      end
      if (acc) sent++;
      cyc++;
    end
    chk("t3 beats delivered", 64'(recv), 64'd8);
    chk("t3 out0 idle", 64'(out_valid[0]), 64'd0);
    chk("t3 pkt1", 64'(stats_out_pkt[32 +: 32]), 64'd2);

    // test 5: async reset mid-packet, then a fresh packet routes normally
    apply(mk(1,1,0,4'd2,32'h61,4'hF,1,4'h4,2,32'h61,1,0), 100);
    @(negedge clk);
    in_sop = 1'b0; in_data = 32'h62;
    rst_n = 1'b0;
    #1 chk("t5 out_valid", 64'(out_valid), 64'd0);
    chk("t5 in_ready", 64'(in_ready), 64'd0);
    chk("t5 pkt lo", 64'(stats_out_pkt[63:0]), 64'd0);
    chk("t5 pkt hi", 64'(stats_out_pkt[127:64]), 64'd0);
    chk("t5 drop", 64'(stats_drop_pkt), 64'd0);
    chk("t5 err", 64'(stats_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    apply(mk(1,1,1,4'd0,32'h71,4'hF,1,4'h1,0,32'h71,1,1), 101);
    apply(mk(0,0,0,4'd0,32'h0,4'hF,1,4'h0,0,32'h0,0,0), 102);
    chk("t5 pkt0", 64'(stats_out_pkt[0 +: 32]), 64'd1);
    chk("t5 err after", 64'(stats_err), 64'd0);

`ifdef FORK_BROADCAST_EN
    // test 6: broadcast 2-beat packet with out3 stalled
    do_reset();
    apply(mk(1,1,0,4'hF,32'h81,4'h7,1,4'hF,3,32'h81,1,0), 200);
    apply(mk(1,0,1,4'h0,32'h82,4'h7,0,4'h8,3,32'h81,1,0), 201);
    apply(mk(1,0,1,4'h0,32'h82,4'h7,0,4'h8,3,32'h81,1,0), 202);
    apply(mk(1,0,1,4'h0,32'h82,4'hF,1,4'hF,0,32'h82,0,1), 203);
    apply(mk(0,0,0,4'h0,32'h0,4'hF,1,4'h0,0,32'h0,0,0), 204);
    for (int k = 0; k < N; k++)
      chk($sformatf("t6 pkt%0d", k), 64'(stats_out_pkt[k*32 +: 32]), 64'd1);
    chk("t6 drop", 64'(stats_drop_pkt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
